// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear FSM state
// encoding and a constant clog2 used for address and counter widths.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Number of bits needed to index 'value' entries (value >= 2).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_clr_ctrl.sv
// Bulk-clear sequencer: sweeps every entry once, one per clock, after a
// single-cycle clr request. A clr seen while sweeping is ignored.
module regfile_clr_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // State and sweep counter registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: start a sweep from entry 0, finish after the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode only registered state, so busy has no input path.
    always_comb begin
        busy    = (state_q == ST_CLEAR);
        clr_we  = (state_q == ST_CLEAR);
        clr_idx = cnt_q;
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: one writer, NUM_RD registered readers,
// per-entry valid bits, sequenced bulk clear and dropped-write flagging.
// Optional feature macro: REGFILE_BYPASS_EN forwards an accepted write to
// any read port sampling the same address in the same cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 4,
    parameter  int NUM_RD = 2,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    wr_e,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_valid,
    input  logic                    clr,
    output logic                    busy,
    output logic                    wr_err
);

    // DEPTH widened by one bit so addresses can be range-checked when
    // DEPTH is not a power of two.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic             wr_err_q, wr_err_d;
    logic             wr_acc;
    logic             clr_we;
    logic [AW-1:0]    clr_idx;

    regfile_clr_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_ctrl (
        .clk     (clk),
        .rst_b   (rst_b),
        .clr     (clr),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    // A write lands only when idle, not colliding with a clear request,
    // and addressed inside the array; anything else is dropped.
    always_comb begin
        wr_acc   = wr_e && !busy && !clr && ({1'b0, wr_addr} < DEPTH_W);
        wr_err_d = wr_e && !wr_acc;
    end

    // Next array contents: clear sweep and accepted write (never both).
    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        if (clr_we) begin
            mem_d[clr_idx] = '0;
            vld_d[clr_idx] = 1'b0;
        end
        if (wr_acc) begin
            mem_d[wr_addr] = wr_data;
            vld_d[wr_addr] = 1'b1;
        end
    end

    // Storage, valid bitmap and write-error pulse.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            vld_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            vld_q    <= vld_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0]    ra;
            logic             ra_ok;
            logic [WIDTH-1:0] rdat_q, rdat_d;
            logic             rvld_q, rvld_d;

            assign ra    = rd_addr[gi*AW +: AW];
            assign ra_ok = ({1'b0, ra} < DEPTH_W);

            // Read mux for this port; out-of-range reads return 0/invalid.
            always_comb begin
                rdat_d = '0;
                rvld_d = 1'b0;
                if (ra_ok) begin
                    rdat_d = mem_q[ra];
                    rvld_d = vld_q[ra];
                end
`ifdef REGFILE_BYPASS_EN
                if (wr_acc && (wr_addr == ra)) begin
                    rdat_d = wr_data;
                    rvld_d = 1'b1;
                end
`endif
            end

            // Registered read data and valid for this port.
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    rdat_q <= '0;
                    rvld_q <= 1'b0;
                end else begin
                    rdat_q <= rdat_d;
                    rvld_q <= rvld_d;
                end
            end

            assign rd_data[gi*WIDTH +: WIDTH] = rdat_q;
            assign rd_valid[gi]               = rvld_q;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a DEPTH=4 instance driven from a vector
// table, and a DEPTH=5 instance for out-of-range and reset-abort cases.
// Build with or without REGFILE_BYPASS_EN; the collision row adapts.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DEPTH=4 instance signals
    logic        rst_b = 1'b1;
    logic        we = 1'b0;
    logic [1:0]  wa = '0;
    logic [7:0]  wd = '0;
    logic        clr = 1'b0;
    logic [1:0]  ra0 = '0, ra1 = '0;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic [1:0]  rd_valid;
    logic        busy, wr_err;

    assign rd_addr = {ra1, ra0};

    regfile_mp #(.WIDTH(8), .DEPTH(4), .NUM_RD(2)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .wr_e     (we),
        .wr_addr  (wa),
        .wr_data  (wd),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .clr      (clr),
        .busy     (busy),
        .wr_err   (wr_err)
    );

    // DEPTH=5 instance signals
    logic        rst5_b = 1'b1;
    logic        we5 = 1'b0;
    logic [2:0]  wa5 = '0;
    logic [7:0]  wd5 = '0;
    logic        clr5 = 1'b0;
    logic [2:0]  ra50 = '0, ra51 = '0;
    logic [5:0]  rd_addr5;
    logic [15:0] rd_data5;
    logic [1:0]  rd_valid5;
    logic        busy5, wr_err5;

    assign rd_addr5 = {ra51, ra50};

    regfile_mp #(.WIDTH(8), .DEPTH(5), .NUM_RD(2)) dut5 (
        .clk      (clk),
        .rst_b    (rst5_b),
        .wr_e     (we5),
        .wr_addr  (wa5),
        .wr_data  (wd5),
        .rd_addr  (rd_addr5),
        .rd_data  (rd_data5),
        .rd_valid (rd_valid5),
        .clr      (clr5),
        .busy     (busy5),
        .wr_err   (wr_err5)
    );

`ifdef REGFILE_BYPASS_EN
    localparam logic [7:0] COL_EXP = 8'hA5;
`else
    localparam logic [7:0] COL_EXP = 8'h22;
`endif

    typedef struct packed {
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic       clr;
        logic [1:0] ra0;
        logic [1:0] ra1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       v0;
        logic       v1;
        logic       busy;
        logic       err;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic w, input logic [1:0] a, input logic [7:0] d,
                                input logic c, input logic [1:0] r0, input logic [1:0] r1,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic ev0, input logic ev1,
                                input logic eb, input logic ee);
        vec_t v;
        v.we = w; v.wa = a; v.wd = d; v.clr = c; v.ra0 = r0; v.ra1 = r1;
        v.d0 = e0; v.d1 = e1; v.v0 = ev0; v.v1 = ev1; v.busy = eb; v.err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        // Each row: inputs sampled at one edge, outputs expected after it.
        //              we  wa  wd     clr r0 r1  d0       d1     v0 v1 busy err
        tbl[0]  = mk(0, 0, 8'h00, 0, 0, 1, 8'h00,   8'h00, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 8'h00, 0, 2, 3, 8'h00,   8'h00, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 8'h11, 0, 1, 2, 8'h00,   8'h00, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 8'h22, 0, 0, 3, 8'h11,   8'h00, 1, 0, 0, 0);
        tbl[4]  = mk(1, 2, 8'h33, 0, 1, 0, 8'h22,   8'h11, 1, 1, 0, 0);
        tbl[5]  = mk(1, 3, 8'h44, 0, 0, 1, 8'h11,   8'h22, 1, 1, 0, 0);
        tbl[6]  = mk(0, 0, 8'h00, 0, 2, 3, 8'h33,   8'h44, 1, 1, 0, 0);
        tbl[7]  = mk(1, 1, 8'hA5, 0, 1, 0, COL_EXP, 8'h11, 1, 1, 0, 0); // collision
        tbl[8]  = mk(0, 0, 8'h00, 0, 1, 1, 8'hA5,   8'hA5, 1, 1, 0, 0);
        tbl[9]  = mk(0, 0, 8'h00, 1, 3, 0, 8'h44,   8'h11, 1, 1, 1, 0); // clr at N
        tbl[10] = mk(1, 0, 8'h77, 0, 0, 3, 8'h11,   8'h44, 1, 1, 1, 1); // dropped, not forwarded
        tbl[11] = mk(0, 0, 8'h00, 1, 3, 0, 8'h44,   8'h00, 1, 0, 1, 0); // clr ignored
        tbl[12] = mk(0, 0, 8'h00, 0, 1, 2, 8'h00,   8'h33, 0, 1, 1, 0);
        tbl[13] = mk(0, 0, 8'h00, 0, 3, 2, 8'h44,   8'h00, 1, 0, 0, 0); // busy falls
        tbl[14] = mk(1, 2, 8'h5A, 0, 3, 0, 8'h00,   8'h00, 0, 0, 0, 0); // first legal write
        tbl[15] = mk(0, 0, 8'h00, 0, 2, 1, 8'h5A,   8'h00, 1, 0, 0, 0);
        tbl[16] = mk(1, 1, 8'h99, 1, 2, 1, 8'h5A,   8'h00, 1, 0, 1, 1); // clr wins
        tbl[17] = mk(0, 0, 8'h00, 0, 1, 2, 8'h00,   8'h5A, 0, 1, 1, 0);
        tbl[18] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00,   8'h00, 0, 0, 1, 0);
        tbl[19] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00,   8'h00, 0, 0, 1, 0);
        tbl[20] = mk(0, 0, 8'h00, 0, 2, 3, 8'h00,   8'h00, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 8'h00, 0, 2, 2, 8'h00,   8'h00, 0, 0, 0, 0);

        // Reset state of both instances while reset is held.
        #2;
        rst_b  = 1'b0;
        rst5_b = 1'b0;
        #1;
        chk("reset_rd_data", {16'h0, rd_data}, 32'h0);
        chk("reset_rd_valid", {30'h0, rd_valid}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_wr_err", {31'h0, wr_err}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_b  = 1'b1;
        rst5_b = 1'b1;

        // Table-driven run on the DEPTH=4 instance.
        for (int i = 0; i < NVEC; i++) begin
            we  = tbl[i].we;
            wa  = tbl[i].wa;
            wd  = tbl[i].wd;
            clr = tbl[i].clr;
            ra0 = tbl[i].ra0;
            ra1 = tbl[i].ra1;
            @(posedge clk);
            #1;
            $display("row %0d: we=%0b wa=%0d wd=%h clr=%0b ra=%0d/%0d -> d=%h/%h v=%b busy=%0b err=%0b",
                     i, we, wa, wd, clr, ra0, ra1, rd_data[7:0], rd_data[15:8],
                     rd_valid, busy, wr_err);
            chk($sformatf("row%0d_d0", i), {24'h0, rd_data[7:0]}, {24'h0, tbl[i].d0});
            chk($sformatf("row%0d_d1", i), {24'h0, rd_data[15:8]}, {24'h0, tbl[i].d1});
            chk($sformatf("row%0d_v0", i), {31'h0, rd_valid[0]}, {31'h0, tbl[i].v0});
            chk($sformatf("row%0d_v1", i), {31'h0, rd_valid[1]}, {31'h0, tbl[i].v1});
            chk($sformatf("row%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].busy});
            chk($sformatf("row%0d_err", i), {31'h0, wr_err}, {31'h0, tbl[i].err});
        end
        we  = 1'b0;
        clr = 1'b0;

        // DEPTH=5: out-of-range write to 6 is dropped; read of 7 is empty.
        we5 = 1'b1; wa5 = 3'd6; wd5 = 8'hEE; ra50 = 3'd7; ra51 = 3'd6;
        @(posedge clk);
        #1;
        $display("d5 wr6: err=%0b d=%h/%h v=%b", wr_err5, rd_data5[7:0], rd_data5[15:8], rd_valid5);
        chk("d5_oor_err", {31'h0, wr_err5}, 32'h1);
        chk("d5_rd7_data", {24'h0, rd_data5[7:0]}, 32'h0);
        chk("d5_rd7_valid", {31'h0, rd_valid5[0]}, 32'h0);

        we5 = 1'b1; wa5 = 3'd4; wd5 = 8'hC3; ra50 = 3'd0; ra51 = 3'd1;
        @(posedge clk);
        #1;
        $display("d5 wr4: err=%0b v=%b", wr_err5, rd_valid5);
        chk("d5_wr4_err", {31'h0, wr_err5}, 32'h0);
        chk("d5_rd01_valid", {30'h0, rd_valid5}, 32'h0);

        we5 = 1'b0; ra50 = 3'd4; ra51 = 3'd2;
        @(posedge clk);
        #1;
        $display("d5 rd4/2: d=%h/%h v=%b", rd_data5[7:0], rd_data5[15:8], rd_valid5);
        chk("d5_rd4_data", {24'h0, rd_data5[7:0]}, 32'hC3);
        chk("d5_rd4_valid", {31'h0, rd_valid5[0]}, 32'h1);
        chk("d5_rd2_valid", {31'h0, rd_valid5[1]}, 32'h0);

        ra50 = 3'd3; ra51 = 3'd6;
        @(posedge clk);
        #1;
        $display("d5 rd3/6: d=%h/%h v=%b", rd_data5[7:0], rd_data5[15:8], rd_valid5);
        chk("d5_rd3_valid", {31'h0, rd_valid5[0]}, 32'h0);
        chk("d5_rd6_data", {24'h0, rd_data5[15:8]}, 32'h0);
        chk("d5_rd6_valid", {31'h0, rd_valid5[1]}, 32'h0);

        // Start a clear, then abort it with reset partway through.
        clr5 = 1'b1;
        @(posedge clk);
        #1;
        clr5 = 1'b0;
        chk("d5_clr_busy1", {31'h0, busy5}, 32'h1);
        @(posedge clk);
        #1;
        chk("d5_clr_busy2", {31'h0, busy5}, 32'h1);
        #2;
        rst5_b = 1'b0;
        #1;
        $display("d5 reset mid-clear: busy=%0b d=%h v=%b", busy5, rd_data5, rd_valid5);
        chk("d5_abort_busy", {31'h0, busy5}, 32'h0);
        chk("d5_abort_data", {16'h0, rd_data5}, 32'h0);
        chk("d5_abort_valid", {30'h0, rd_valid5}, 32'h0);
        #1;
        rst5_b = 1'b1;
        ra50 = 3'd4; ra51 = 3'd0;
        @(posedge clk);
        #1;
        $display("d5 after reset rd4/0: d=%h/%h v=%b busy=%0b", rd_data5[7:0], rd_data5[15:8], rd_valid5, busy5);
        chk("d5_post_rd4_data", {24'h0, rd_data5[7:0]}, 32'h0);
        chk("d5_post_rd4_valid", {31'h0, rd_valid5[0]}, 32'h0);
        chk("d5_post_busy", {31'h0, busy5}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
